// File: rtl/hilo_pkg.sv
// Shared types and helpers for the HI/LO writeback stage.
package hilo_pkg;
  localparam int HILO_W = 32;

  typedef enum logic {HL_EMPTY, HL_PENDING} hl_state_t;

  function automatic logic [HILO_W-1:0] z_hi(input logic [2*HILO_W-1:0] z);
    return z[2*HILO_W-1:HILO_W];
  endfunction

  function automatic logic [HILO_W-1:0] z_lo(input logic [2*HILO_W-1:0] z);
    return z[HILO_W-1:0];
  endfunction
endpackage

// File: rtl/hilo_reg.sv
// WIDTH-bit enabled register with asynchronous active-low clear.
module hilo_reg import hilo_pkg::*; #(
  parameter int WIDTH = HILO_W
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear)  r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/hilo_writeback.sv
// One-entry pending slot in front of architectural HI/LO, with bypass,
// program-ordered mthi/mtlo merging and a sticky divide-by-zero flag.
module hilo_writeback import hilo_pkg::*; #(
  parameter int WIDTH = HILO_W
) (
  input  logic               i_clk,
  input  logic               i_clear,
  input  logic               i_res_valid,
  output logic               o_res_ready,
  input  logic [2*WIDTH-1:0] i_res_z,
  input  logic               i_res_dz,
  input  logic               i_wb_stall,
  input  logic               i_mthi,
  input  logic               i_mtlo,
  input  logic [WIDTH-1:0]   i_mt_data,
  input  logic               i_dz_clr,
  output logic [WIDTH-1:0]   o_hi_out,
  output logic [WIDTH-1:0]   o_lo_out,
  output logic               o_hilo_busy,
  output logic               o_dz_flag
);
  hl_state_t        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_p_hi, r_p_lo;
  logic             r_p_dz, r_dz;
  logic [WIDTH-1:0] w_z_hi, w_z_lo, w_hi_q, w_lo_q, w_hi_d, w_lo_d;
  logic             w_pend, w_accept, w_commit, w_held, w_hi_en, w_lo_en;

  generate
    if (WIDTH == HILO_W) begin : g_pkg_slice
      assign w_z_hi = z_hi(i_res_z);
      assign w_z_lo = z_lo(i_res_z);
    end else begin : g_raw_slice
      assign w_z_hi = i_res_z[2*WIDTH-1:WIDTH];
      assign w_z_lo = i_res_z[WIDTH-1:0];
    end
  endgenerate

  assign w_pend      = (r_state == HL_PENDING);
  assign o_res_ready = i_clear & (!w_pend | !i_wb_stall);
  assign w_accept    = i_res_valid & o_res_ready;
  assign w_commit    = w_pend & !i_wb_stall;
  assign w_held      = w_pend & i_wb_stall;

  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) r_state <= HL_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HL_EMPTY:   if (w_accept) w_state_nxt = HL_PENDING;
      HL_PENDING: if (w_commit && !w_accept) w_state_nxt = HL_EMPTY;
      default:    w_state_nxt = HL_EMPTY;
    endcase
  end

  // mt writes are younger than a held entry but older than a fresh accept.
  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) begin
      r_p_hi <= '0;
      r_p_lo <= '0;
      r_p_dz <= 1'b0;
    end else if (w_accept) begin
      r_p_hi <= w_z_hi;
      r_p_lo <= w_z_lo;
      r_p_dz <= i_res_dz;
    end else if (w_held) begin
      if (i_mthi) r_p_hi <= i_mt_data;
      if (i_mtlo) r_p_lo <= i_mt_data;
    end
  end

  assign w_hi_en = w_commit | i_mthi;
  assign w_lo_en = w_commit | i_mtlo;
  assign w_hi_d  = i_mthi ? i_mt_data : r_p_hi;
  assign w_lo_d  = i_mtlo ? i_mt_data : r_p_lo;

  hilo_reg #(.WIDTH(WIDTH)) u_hi (
    .i_clk(i_clk), .i_clear(i_clear), .i_en(w_hi_en), .i_d(w_hi_d), .o_q(w_hi_q)
  );
  hilo_reg #(.WIDTH(WIDTH)) u_lo (
    .i_clk(i_clk), .i_clear(i_clear), .i_en(w_lo_en), .i_d(w_lo_d), .o_q(w_lo_q)
  );

  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear)                r_dz <= 1'b0;
    else if (w_commit && r_p_dz) r_dz <= 1'b1;
    else if (i_dz_clr)           r_dz <= 1'b0;
  end

  assign o_hi_out    = w_pend ? r_p_hi : w_hi_q;
  assign o_lo_out    = w_pend ? r_p_lo : w_lo_q;
  assign o_hilo_busy = w_pend;
  assign o_dz_flag   = r_dz;
endmodule

// File: tb/tb_hilo_writeback.sv
// Scoreboard bench for hilo_writeback: directed scenarios then random traffic
// against a queue-based reference model of HI/LO, pending slot and dz flag.
module tb_hilo_writeback;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           clear, res_valid, res_ready, res_dz, wb_stall;
  logic           mthi, mtlo, dz_clr, hilo_busy, dz_flag;
  logic [2*W-1:0] res_z;
  logic [W-1:0]   mt_data, hi_out, lo_out;

  hilo_writeback #(.WIDTH(W)) dut (
    .i_clk(clk), .i_clear(clear), .i_res_valid(res_valid), .o_res_ready(res_ready),
    .i_res_z(res_z), .i_res_dz(res_dz), .i_wb_stall(wb_stall), .i_mthi(mthi),
    .i_mtlo(mtlo), .i_mt_data(mt_data), .i_dz_clr(dz_clr), .o_hi_out(hi_out),
    .o_lo_out(lo_out), .o_hilo_busy(hilo_busy), .o_dz_flag(dz_flag)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; logic dz; } entry_t;
  typedef struct { logic rdy; logic [W-1:0] hi; logic [W-1:0] lo; logic busy; logic dz; } exp_t;

  // reference model: architectural registers, pending slot as a queue (<=1 deep)
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_dz = 1'b0;
  entry_t       pend[$];
  exp_t         sb[$];
  int           n_tests = 0, n_fail = 0;

  task automatic cyc(input logic clr, input logic valid, input logic [2*W-1:0] z,
                     input logic zdz, input logic stall, input logic mh, input logic ml,
                     input logic [W-1:0] mt, input logic dzc);
    exp_t   e;
    entry_t c, n;
    logic   rdy, commit, held;
    @(posedge clk); #1;
    clear = clr; res_valid = valid; res_z = z; res_dz = zdz; wb_stall = stall;
    mthi = mh; mtlo = ml; mt_data = mt; dz_clr = dzc;
    if (!clr) begin
      m_hi = '0; m_lo = '0; m_dz = 1'b0; pend.delete();
    end
    rdy    = clr && (pend.size() == 0 || !stall);
    e.rdy  = rdy;
    e.busy = (pend.size() != 0);
    e.hi   = e.busy ? pend[0].hi : m_hi;
    e.lo   = e.busy ? pend[0].lo : m_lo;
    e.dz   = m_dz;
    sb.push_back(e);
    if (clr) begin
      commit = (pend.size() != 0) && !stall;
      held   = (pend.size() != 0) && stall;
      if (commit) begin
        c = pend.pop_front();
        m_hi = c.hi; m_lo = c.lo;
      end
      if (mh) m_hi = mt;
      if (ml) m_lo = mt;
      if (held && mh) pend[0].hi = mt;
      if (held && ml) pend[0].lo = mt;
      if (commit && c.dz) m_dz = 1'b1;
      else if (dzc)       m_dz = 1'b0;
      if (valid && rdy) begin
        n.hi = z[2*W-1:W]; n.lo = z[W-1:0]; n.dz = zdz;
        pend.push_back(n);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, '0, 0, 0, 0, 0, '0, 0);
  endtask

  // monitor: outputs are presented every cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests += 5;
      if (res_ready !== e.rdy) begin
        n_fail++; $display("FAIL res_ready t=%0t got %b want %b", $time, res_ready, e.rdy);
      end
      if (hi_out !== e.hi) begin
        n_fail++; $display("FAIL hi_out t=%0t got %h want %h", $time, hi_out, e.hi);
      end
      if (lo_out !== e.lo) begin
        n_fail++; $display("FAIL lo_out t=%0t got %h want %h", $time, lo_out, e.lo);
      end
      if (hilo_busy !== e.busy) begin
        n_fail++; $display("FAIL hilo_busy t=%0t got %b want %b", $time, hilo_busy, e.busy);
      end
      if (dz_flag !== e.dz) begin
        n_fail++; $display("FAIL dz_flag t=%0t got %b want %b", $time, dz_flag, e.dz);
      end
    end
  end

  initial begin
    clear = 0; res_valid = 0; res_z = '0; res_dz = 0; wb_stall = 0;
    mthi = 0; mtlo = 0; mt_data = '0; dz_clr = 0;
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0, 0, 0, '0, 0);
    idle(2);
    // -7/2: q = -3, r = -1
    cyc(1, 1, 64'hFFFFFFFF_FFFFFFFD, 0, 0, 0, 0, '0, 0);
    idle(3);
    // stall with a second result waiting, then commit + accept on one edge
    cyc(1, 1, 64'h11111111_22222222, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 64'h33333333_44444444, 0, 1, 0, 0, '0, 0);
    cyc(1, 1, 64'h33333333_44444444, 0, 0, 0, 0, '0, 0);
    idle(3);
    // mthi into a stalled entry
    cyc(1, 1, 64'hAAAAAAAA_BBBBBBBB, 0, 0, 0, 0, '0, 0);
    cyc(1, 0, '0, 0, 1, 1, 0, 32'h12345678, 0);
    cyc(1, 0, '0, 0, 1, 0, 0, '0, 0);
    idle(3);
    // mt on the same edge as commit and as accept
    cyc(1, 1, 64'hCCCCCCCC_DDDDDDDD, 0, 0, 0, 0, '0, 0);
    cyc(1, 1, 64'hEEEEEEEE_FFFFFFFF, 0, 0, 1, 1, 32'h0BADF00D, 0);
    idle(3);
    // sticky dz flag
    cyc(1, 1, '0, 1, 0, 0, 0, '0, 0);
    idle(2);
    cyc(1, 1, 64'h5, 1, 0, 0, 0, '0, 0);
    cyc(1, 0, '0, 0, 0, 0, 0, '0, 1);
    idle(2);
    cyc(1, 0, '0, 0, 0, 0, 0, '0, 1);
    idle(2);
    // clear while pending: entry discarded
    cyc(1, 1, 64'h98765432_10FEDCBA, 1, 1, 0, 0, '0, 0);
    cyc(1, 0, '0, 0, 1, 0, 0, '0, 0);
    cyc(0, 0, '0, 0, 0, 0, 0, '0, 0);
    idle(3);
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1), {$urandom, $urandom},
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom,
          ($urandom_range(0, 7) == 0));
    idle(2);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expectations want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
